// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM/WB pipeline stage.
package mem_wb_stage_pkg;

  localparam int MWB_DSIZE   = 16;
  localparam int MWB_ASIZE   = 4;
  localparam int MWB_TIMEOUT = 15;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // 2'b11 is reserved and behaves like a plain ALU op.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_wb_stage_mem_wait_timer.sv
// Wait counter for an outstanding data-memory access; expired is high once the
// count reaches TIMEOUT. No backpressure; clear has priority over enable.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU ops retire 1 cycle after acceptance, loads 1 cycle after dmem_ack.
// stall holds upstream while an access is outstanding; accesses abort after TIMEOUT waits.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DSIZE   = MWB_DSIZE,
  parameter int ASIZE   = MWB_ASIZE,
  parameter int TIMEOUT = MWB_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [DSIZE-1:0] sdata_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic [1:0]       memop_in,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic [DSIZE-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_wdata,
  output logic             mem_err
);

  state_e state_d, state_q;

  logic             req_d, req_q;
  logic             we_d, we_q;
  logic [DSIZE-1:0] addr_d, addr_q;
  logic [DSIZE-1:0] sdata_d, sdata_q;
  logic [ASIZE-1:0] pend_waddr_d, pend_waddr_q;
  logic             pend_ld_d, pend_ld_q;
  logic             wb_wen_d, wb_wen_q;
  logic [ASIZE-1:0] wb_waddr_d, wb_waddr_q;
  logic [DSIZE-1:0] wb_wdata_d, wb_wdata_q;
  logic             mem_err_d, mem_err_q;

  logic tmr_clr, tmr_en, tmr_expired;
  logic accept_mem;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign accept_mem = valid_in && is_mem_op(memop_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sdata_q      <= '0;
      pend_waddr_q <= '0;
      pend_ld_q    <= 1'b0;
      wb_wen_q     <= 1'b0;
      wb_waddr_q   <= '0;
      wb_wdata_q   <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sdata_q      <= sdata_d;
      pend_waddr_q <= pend_waddr_d;
      pend_ld_q    <= pend_ld_d;
      wb_wen_q     <= wb_wen_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_wdata_q   <= wb_wdata_d;
      mem_err_q    <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (accept_mem) state_d = ST_BUSY;
    end else begin
      if (dmem_ack || tmr_expired) state_d = ST_IDLE;
    end
  end

  always_comb begin
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    pend_waddr_d = pend_waddr_q;
    pend_ld_d    = pend_ld_q;
    wb_wen_d     = 1'b0;
    wb_waddr_d   = wb_waddr_q;
    wb_wdata_d   = wb_wdata_q;
    mem_err_d    = mem_err_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept_mem) begin
        req_d        = 1'b1;
        we_d         = (memop_in == MEM_STORE);
        addr_d       = alu_in;
        sdata_d      = sdata_in;
        pend_waddr_d = waddr_in;
        pend_ld_d    = (memop_in == MEM_LOAD);
        tmr_clr      = 1'b1;
      end else if (valid_in) begin
        wb_wen_d   = wen_in;
        wb_waddr_d = waddr_in;
        wb_wdata_d = alu_in;
      end
    end else begin
      // An ack arriving on the expiry cycle still completes the access.
      if (dmem_ack) begin
        req_d = 1'b0;
        if (pend_ld_q) begin
          wb_wen_d   = 1'b1;
          wb_waddr_d = pend_waddr_q;
          wb_wdata_d = dmem_rdata;
        end
      end else if (tmr_expired) begin
        req_d     = 1'b0;
        mem_err_d = 1'b1;
      end else begin
        tmr_en = 1'b1;
      end
    end
  end

  assign stall      = valid_in && (state_q == ST_BUSY);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = sdata_q;
  assign wb_wen     = wb_wen_q;
  assign wb_waddr   = wb_waddr_q;
  assign wb_wdata   = wb_wdata_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; writebacks are checked against a queue of expected results.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] alu_in = '0;
  logic [15:0] sdata_in = '0;
  logic [3:0]  waddr_in = '0;
  logic        wen_in = 1'b0;
  logic [1:0]  memop_in = '0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_wen;
  logic [3:0]  wb_waddr;
  logic [15:0] wb_wdata;
  logic        mem_err;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  mem_wb_stage dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .alu_in     (alu_in),
    .sdata_in   (sdata_in),
    .waddr_in   (waddr_in),
    .wen_in     (wen_in),
    .memop_in   (memop_in),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] wa, input logic we, input logic [1:0] op);
    valid_in = v;
    alu_in   = alu;
    sdata_in = sd;
    waddr_in = wa;
    wen_in   = we;
    memop_in = op;
  endtask

  // Monitor: every writeback pulse must match the oldest expected entry.
  always @(negedge clk) begin
    wb_t e;
    if (rst && wb_wen) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got waddr=%0h wdata=%0h, expected no writeback",
                 wb_waddr, wb_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wb_waddr", {28'd0, wb_waddr}, {28'd0, e.a});
        chk("wb_wdata", {16'd0, wb_wdata}, {16'd0, e.d});
      end
    end
  end

  initial begin
    int n;

    // 1: reset and ack while idle
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    repeat (3) tick;
    rst = 1'b1;
    tick;
    chk("rst_dmem", {dmem_req, dmem_we, dmem_addr, dmem_wdata[13:0]}, 32'd0);
    chk("rst_wb", {wb_wen, wb_waddr, wb_wdata, mem_err, stall}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 16'hFFFF;
    tick;
    dmem_ack = 1'b0;
    chk("idle_ack_ignored", {dmem_req, wb_wen, wb_wdata, mem_err}, 32'd0);

    // 2: ALU op, 1-cycle latency, no stall
    drive(1'b1, 16'h00A5, 16'h0, 4'd3, 1'b1, MEM_NONE);
    exp_q.push_back('{a: 4'd3, d: 16'h00A5});
    chk("alu_stall", stall, 0);
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    chk("alu_latency", wb_wen, 1);
    chk("alu_no_req", dmem_req, 0);
    tick;
    chk("alu_wen_pulse", wb_wen, 0);

    // 3: load, ack on 4th request cycle, followed by ALU op
    drive(1'b1, 16'h0010, 16'h0, 4'd5, 1'b1, MEM_LOAD);
    exp_q.push_back('{a: 4'd5, d: 16'hBEEF});
    exp_q.push_back('{a: 4'd6, d: 16'h0077});
    chk("load_accept_stall", stall, 0);
    tick;
    drive(1'b1, 16'h0077, 16'h0, 4'd6, 1'b1, MEM_NONE);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      if (dmem_req && dmem_addr == 16'h0010 && !dmem_we && stall) n++;
      if (i == 4) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hBEEF;
      end
      tick;
    end
    dmem_ack = 1'b0;
    chk("load_req_cycles", n, 4);
    chk("load_req_drop", dmem_req, 0);
    chk("load_wb_latency", wb_wen, 1);
    chk("load_unstall", stall, 0);
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    chk("follow_alu_wb", wb_wen, 1);
    tick;

    // 4: store with held op behind it
    drive(1'b1, 16'h0020, 16'h1234, 4'd7, 1'b1, MEM_STORE);
    tick;
    drive(1'b1, 16'h0055, 16'h0, 4'd8, 1'b1, MEM_NONE);
    exp_q.push_back('{a: 4'd8, d: 16'h0055});
    chk("store_we", dmem_we, 1);
    chk("store_wdata", dmem_wdata, 16'h1234);
    chk("store_addr", dmem_addr, 16'h0020);
    n = 0;
    for (int i = 1; i <= 3; i++) begin
      if (stall && dmem_req) n++;
      if (i == 3) dmem_ack = 1'b1;
      tick;
    end
    dmem_ack = 1'b0;
    chk("store_stall_cycles", n, 3);
    chk("store_no_wb", wb_wen, 0);
    chk("store_unstall", stall, 0);
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    chk("held_op_wb", wb_wen, 1);
    tick;
    chk("held_op_once", wb_wen, 0);

    // 5a: load timeout
    drive(1'b1, 16'h0030, 16'h0, 4'd9, 1'b1, MEM_LOAD);
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    n = 0;
    while (dmem_req && n < 40) begin
      n++;
      tick;
    end
    chk("timeout_req_cycles", n, 16);
    chk("timeout_err", mem_err, 1);
    repeat (3) tick;
    chk("timeout_err_sticky", mem_err, 1);
    chk("timeout_no_wb", wb_wen, 0);

    // 6: async reset during an access
    drive(1'b1, 16'h0044, 16'h0, 4'd11, 1'b1, MEM_LOAD);
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    chk("busy_req", dmem_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_req", dmem_req, 0);
    chk("rst_clears_err", mem_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick;
    chk("rst_after_state", {dmem_req, wb_wen, mem_err}, 32'd0);

    // 5b: ack on the timeout cycle completes normally
    drive(1'b1, 16'h0040, 16'h0, 4'd10, 1'b1, MEM_LOAD);
    exp_q.push_back('{a: 4'd10, d: 16'hCAFE});
    tick;
    drive(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, MEM_NONE);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      if (dmem_req) n++;
      if (i == 16) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 16'hCAFE;
      end
      tick;
    end
    dmem_ack = 1'b0;
    chk("late_ack_req_cycles", n, 16);
    chk("late_ack_wb", wb_wen, 1);
    chk("late_ack_no_err", mem_err, 0);
    chk("late_ack_req_drop", dmem_req, 0);

    repeat (2) tick;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
